// File: rtl/mult_3_writeback_pkg.sv
// Shared multiplier definitions: widths, the zero register index and the
// layout of one finished writeback entry.
package mult_3_writeback_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int PROD_W = 64;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0]  regdest;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } mult_entry_t;

  localparam int ENTRY_W = $bits(mult_entry_t);

endpackage

// File: rtl/mult_3_writeback_fifo.sv
// Result FIFO for the writeback stage. Storage is not reset; only the
// pointers and occupancy count clear, which is enough to discard contents.
module mult_result_fifo
  import mult_3_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  mult_entry_t       wdata_i,
  output mult_entry_t       rdata_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  mult_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mult_3_writeback.sv
// Final multiplier stage: sign correction, zero forcing and a small result
// FIFO that absorbs writeback back-pressure with a sticky overflow flag.
module mult_3_writeback
  import mult_3_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               m2_m3_oper,
  input  logic [PROD_W-1:0]  m2_m3_multres,
  input  logic [REG_W-1:0]   m2_m3_regdest,
  input  logic               m2_m3_ispositive,
  input  logic               m2_m3_iszero,
  input  logic               wb_m3_ready,
  output logic               m3_wb_valid,
  output logic [REG_W-1:0]   m3_wb_regdest,
  output logic [DATA_W-1:0]  m3_wb_lo,
  output logic [DATA_W-1:0]  m3_wb_hi,
  output logic [CNT_W-1:0]   m3_count,
  output logic               m3_overflow
);

  logic [PROD_W-1:0] res;
  mult_entry_t       wr_entry;
  mult_entry_t       head;
  logic              push_req, push_ok, pop;
  logic              full, empty;
  logic              overflow_q, overflow_d;

  always_comb begin
    res = m2_m3_multres;
    if (m2_m3_iszero)          res = '0;
    else if (!m2_m3_ispositive) res = ~m2_m3_multres + PROD_W'(1);
  end

  assign wr_entry.regdest = m2_m3_regdest;
  assign wr_entry.hi      = res[PROD_W-1:DATA_W];
  assign wr_entry.lo      = res[DATA_W-1:0];

  // Writes to r0 are architecturally dead, so they never occupy a slot.
  assign push_req = m2_m3_oper && (m2_m3_regdest != REG_ZERO);
  assign pop      = !empty && wb_m3_ready;
  assign push_ok  = push_req && (!full || pop);

  assign overflow_d = overflow_q || (push_req && full && !pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  mult_result_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push_ok),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (m3_count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Head fields are masked when empty so stale storage never leaks out.
  assign m3_wb_valid   = !empty;
  assign m3_wb_regdest = empty ? REG_ZERO : head.regdest;
  assign m3_wb_lo      = empty ? '0 : head.lo;
  assign m3_wb_hi      = empty ? '0 : head.hi;
  assign m3_overflow   = overflow_q;

endmodule

// File: tb/tb_mult_3_writeback.sv
// Self-checking bench for mult_3_writeback: directed table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_mult_3_writeback;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        m2_m3_oper;
  logic [63:0] m2_m3_multres;
  logic [4:0]  m2_m3_regdest;
  logic        m2_m3_ispositive;
  logic        m2_m3_iszero;
  logic        wb_m3_ready;
  logic        m3_wb_valid;
  logic [4:0]  m3_wb_regdest;
  logic [31:0] m3_wb_lo;
  logic [31:0] m3_wb_hi;
  logic [CNT_W-1:0] m3_count;
  logic        m3_overflow;

  int total = 0;
  int bad   = 0;

  mult_3_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .m2_m3_oper       (m2_m3_oper),
    .m2_m3_multres    (m2_m3_multres),
    .m2_m3_regdest    (m2_m3_regdest),
    .m2_m3_ispositive (m2_m3_ispositive),
    .m2_m3_iszero     (m2_m3_iszero),
    .wb_m3_ready      (wb_m3_ready),
    .m3_wb_valid      (m3_wb_valid),
    .m3_wb_regdest    (m3_wb_regdest),
    .m3_wb_lo         (m3_wb_lo),
    .m3_wb_hi         (m3_wb_hi),
    .m3_count         (m3_count),
    .m3_overflow      (m3_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        oper;
    logic [63:0] multres;
    logic [4:0]  rd;
    logic        pos;
    logic        zero;
    logic        exp_valid;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic oper, input logic [63:0] m, input logic [4:0] rd,
                       input logic pos, input logic zero);
    m2_m3_oper       = oper;
    m2_m3_multres    = m;
    m2_m3_regdest    = rd;
    m2_m3_ispositive = pos;
    m2_m3_iszero     = zero;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    #2 reset = 1'b1;
    step();
  endtask

  // Reference model: plain two's-complement arithmetic and a bounded queue.
  logic [4:0]  mq_rd  [$];
  logic [63:0] mq_res [$];
  logic        m_ovf;

  task automatic model_edge();
    logic [63:0] r;
    if (m2_m3_iszero)          r = 64'd0;
    else if (m2_m3_ispositive) r = m2_m3_multres;
    else                       r = 64'd0 - m2_m3_multres;
    if (mq_rd.size() > 0 && wb_m3_ready) begin
      void'(mq_rd.pop_front());
      void'(mq_res.pop_front());
    end
    if (m2_m3_oper && m2_m3_regdest != 5'd0) begin
      if (mq_rd.size() < DEPTH) begin
        mq_rd.push_back(m2_m3_regdest);
        mq_res.push_back(r);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic model_check(input string tag);
    logic        ev;
    logic [4:0]  erd;
    logic [63:0] eres;
    ev   = (mq_rd.size() > 0);
    erd  = ev ? mq_rd[0] : 5'd0;
    eres = ev ? mq_res[0] : 64'd0;
    check({tag, ".count"},   64'(m3_count), 64'(mq_rd.size()));
    check({tag, ".valid"},   64'(m3_wb_valid), 64'(ev));
    check({tag, ".regdest"}, 64'(m3_wb_regdest), 64'(erd));
    check({tag, ".res"},     {m3_wb_hi, m3_wb_lo}, eres);
    check({tag, ".ovf"},     64'(m3_overflow), 64'(m_ovf));
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 64'd42,                    5'd3,  1'b1, 1'b0, 1'b1, 32'd42,        32'd0};
    vecs[1] = '{1'b1, 64'd6,                     5'd7,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFFA, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 64'hDEAD_BEEF_0000_0001,   5'd9,  1'b0, 1'b1, 1'b1, 32'd0,         32'd0};
    vecs[3] = '{1'b1, 64'd5,                     5'd0,  1'b1, 1'b0, 1'b0, 32'd0,         32'd0};
    vecs[4] = '{1'b0, 64'd77,                    5'd4,  1'b1, 1'b0, 1'b0, 32'd0,         32'd0};
    vecs[5] = '{1'b1, 64'h8000_0000_0000_0000,   5'd31, 1'b0, 1'b0, 1'b1, 32'd0,         32'h8000_0000};
    vecs[6] = '{1'b1, 64'd1,                     5'd12, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    reset = 1'b0;
    wb_m3_ready = 1'b0;
    idle();
    #1;
    check("rst.valid",   64'(m3_wb_valid), 64'd0);
    check("rst.count",   64'(m3_count), 64'd0);
    check("rst.regdest", 64'(m3_wb_regdest), 64'd0);
    check("rst.res",     {m3_wb_hi, m3_wb_lo}, 64'd0);
    check("rst.ovf",     64'(m3_overflow), 64'd0);
    step();
    #2 reset = 1'b1;
    step();

    // Directed table: each vector pushed with ready high, then popped next edge.
    wb_m3_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].oper, vecs[i].multres, vecs[i].rd, vecs[i].pos, vecs[i].zero);
      step();
      check($sformatf("vec%0d.valid", i), 64'(m3_wb_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d.lo", i), 64'(m3_wb_lo), 64'(vecs[i].exp_lo));
      check($sformatf("vec%0d.hi", i), 64'(m3_wb_hi), 64'(vecs[i].exp_hi));
      check($sformatf("vec%0d.regdest", i), 64'(m3_wb_regdest),
            vecs[i].exp_valid ? 64'(vecs[i].rd) : 64'd0);
      check($sformatf("vec%0d.count", i), 64'(m3_count), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d.ovf", i), 64'(m3_overflow), 64'd0);
      idle();
      step();
      check($sformatf("vec%0d.popped", i), 64'(m3_wb_valid), 64'd0);
    end

    // Fill and overflow.
    wb_m3_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 64'(100 + k), 5'(k), 1'b1, 1'b0);
      step();
      check($sformatf("fill%0d.count", k), 64'(m3_count), 64'(k > 4 ? 4 : k));
      check($sformatf("fill%0d.ovf", k), 64'(m3_overflow), 64'(k == 5));
      check($sformatf("fill%0d.head", k), 64'(m3_wb_regdest), 64'd1);
    end
    idle();
    wb_m3_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain%0d.regdest", k), 64'(m3_wb_regdest), 64'(k));
      check($sformatf("drain%0d.lo", k), 64'(m3_wb_lo), 64'(100 + k));
      step();
    end
    check("drain.valid", 64'(m3_wb_valid), 64'd0);
    check("drain.ovf",   64'(m3_overflow), 64'd1);

    // Mid-operation asynchronous reset with three entries held.
    wb_m3_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 64'(200 + k), 5'(k + 10), 1'b1, 1'b0);
      step();
    end
    idle();
    check("prerst.count", 64'(m3_count), 64'd3);
    #2 reset = 1'b0;
    #1;
    check("midrst.count", 64'(m3_count), 64'd0);
    check("midrst.valid", 64'(m3_wb_valid), 64'd0);
    check("midrst.res",   {m3_wb_hi, m3_wb_lo}, 64'd0);
    check("midrst.regdest", 64'(m3_wb_regdest), 64'd0);
    check("midrst.ovf",   64'(m3_overflow), 64'd0);
    step();
    #2 reset = 1'b1;
    step();
    check("postrst.count", 64'(m3_count), 64'd0);
    check("postrst.valid", 64'(m3_wb_valid), 64'd0);

    // Full with push and pop on the same edge.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 64'(10 + k), 5'(k), 1'b0, 1'b0);
      step();
    end
    wb_m3_ready = 1'b1;
    drive(1'b1, 64'd15, 5'd5, 1'b0, 1'b0);
    step();
    check("fullpp.count", 64'(m3_count), 64'd4);
    check("fullpp.ovf",   64'(m3_overflow), 64'd0);
    idle();
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("fullpp%0d.regdest", k), 64'(m3_wb_regdest), 64'(k));
      check($sformatf("fullpp%0d.res", k), {m3_wb_hi, m3_wb_lo}, 64'd0 - 64'(10 + k));
      step();
    end
    check("fullpp.empty", 64'(m3_wb_valid), 64'd0);

    // Randomized run against the reference model.
    do_reset();
    mq_rd.delete();
    mq_res.delete();
    m_ovf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, {$urandom, $urandom}, 5'($urandom % 8),
            1'($urandom), ($urandom % 8) == 0);
      wb_m3_ready = (c < 200) ? (($urandom % 3) == 0) : (($urandom % 4) != 0);
      model_edge();
      step();
      model_check($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
